// File: rtl/obj_line_reader.sv
// rtl/obj_line_reader.sv - OBJ row-buffer scan-out: line timing, packet decode, 2-entry pixel FIFO
module obj_line_reader #(
  parameter int unsigned CYCLES_PER_LINE  = 1232,
  parameter int unsigned CYCLES_PER_PIXEL = 4,
  parameter int unsigned H_ACTIVE         = 240,
  parameter int unsigned V_ACTIVE         = 160,
  parameter int unsigned V_TOTAL          = 228
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [19:0] obj_packet,
  output logic [7:0]  hcount,
  output logic [7:0]  vcount,
  output logic        hblank,
  output logic        vblank,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_x,
  output logic [1:0]  pix_pri,
  output logic [7:0]  pix_index,
  output logic        pix_opaque,
  output logic        pix_semitrans,
  output logic        pix_win,
  output logic        pix_overrun
);

  localparam int LCW = $clog2(CYCLES_PER_LINE);
  localparam int PHW = (CYCLES_PER_PIXEL > 1) ? $clog2(CYCLES_PER_PIXEL) : 1;
  localparam logic [LCW-1:0] LC_LAST   = LCW'(CYCLES_PER_LINE - 1);
  localparam logic [LCW-1:0] LC_HBLANK = LCW'(H_ACTIVE * CYCLES_PER_PIXEL);
  localparam logic [PHW-1:0] PH_LAST   = PHW'(CYCLES_PER_PIXEL - 1);
  localparam logic [PHW-1:0] PH_SAMPLE = PHW'(1);
  localparam logic [7:0]     V_LAST    = 8'(V_TOTAL - 1);
  localparam logic [7:0]     V_VIS     = 8'(V_ACTIVE);

  typedef struct packed {
    logic [7:0] x;
    logic [1:0] pri;
    logic [7:0] index;
    logic       opaque;
    logic       semitrans;
    logic       win;
  } pix_t;

  logic [LCW-1:0] lc;
  logic [LCW-1:0] lc_next;
  logic [PHW-1:0] ph;
  logic           line_end;
  logic           frame_end;
  logic           push;
  logic           pop;
  logic           accept;
  logic           visible;
  logic [1:0]     mode;
  pix_t           dec;
  pix_t           mem [2];
  logic           rd_ptr;
  logic           wr_ptr;
  logic [1:0]     count;
  logic           unused_bits;

  // Layer id and reserved bits carry nothing this block needs.
  assign unused_bits = ^{obj_packet[17:15], obj_packet[12:9]};

  always_comb begin
    line_end      = (lc == LC_LAST);
    frame_end     = line_end && (vcount == V_LAST);
    lc_next       = line_end ? '0 : lc + LCW'(1);
    mode          = obj_packet[14:13];
    visible       = enable && obj_packet[8] && (obj_packet[7:0] != 8'd0);
    dec.x         = hcount;
    dec.pri       = obj_packet[19:18];
    dec.index     = obj_packet[7:0];
    dec.opaque    = visible && (mode != 2'd2);
    dec.semitrans = visible && (mode == 2'd1);
    dec.win       = visible && (mode == 2'd2);
    push          = (ph == PH_SAMPLE) && !hblank && !vblank;
    pop           = pix_valid && pix_ready;
    // A full FIFO still takes the new pixel when the head leaves in the same cycle.
    accept        = push && ((count != 2'd2) || pop);
  end

  assign pix_valid = (count != 2'd0);
  assign {pix_x, pix_pri, pix_index, pix_opaque, pix_semitrans, pix_win} = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      lc          <= '0;
      ph          <= '0;
      hcount      <= 8'd0;
      vcount      <= 8'd0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      mem[0]      <= '0;
      mem[1]      <= '0;
      pix_overrun <= 1'b0;
    end else begin
      lc     <= lc_next;
      ph     <= (line_end || (ph == PH_LAST)) ? '0 : ph + PHW'(1);
      hblank <= (lc_next >= LC_HBLANK);
      if (line_end)
        hcount <= 8'd0;
      else if (ph == PH_LAST)
        hcount <= (lc_next < LC_HBLANK) ? hcount + 8'd1 : 8'd0;
      if (line_end) begin
        vcount <= frame_end ? 8'd0 : vcount + 8'd1;
        vblank <= frame_end ? (V_VIS == 8'd0) : ((vcount + 8'd1) >= V_VIS);
      end
      if (accept) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, accept} - {1'b0, pop};
      if (frame_end)
        pix_overrun <= 1'b0;
      else if (push && !accept)
        pix_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obj_line_reader.sv
// tb/tb_obj_line_reader.sv - bench for obj_line_reader with a shortened frame height
module tb_obj_line_reader;
  localparam int VA  = 12;
  localparam int VT  = 18;
  localparam int CPL = 1232;
  localparam int HB  = 960;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        pix_ready = 1'b1;
  logic [19:0] obj_packet;
  logic [7:0]  hcount, vcount, pix_x, pix_index;
  logic        hblank, vblank, pix_valid, pix_opaque, pix_semitrans, pix_win, pix_overrun;
  logic [1:0]  pix_pri;
  logic [19:0] pkt_mem [240];

  obj_line_reader #(
    .CYCLES_PER_LINE(CPL), .CYCLES_PER_PIXEL(4), .H_ACTIVE(240),
    .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .obj_packet(obj_packet),
    .hcount(hcount), .vcount(vcount), .hblank(hblank), .vblank(vblank),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_pri(pix_pri),
    .pix_index(pix_index), .pix_opaque(pix_opaque), .pix_semitrans(pix_semitrans),
    .pix_win(pix_win), .pix_overrun(pix_overrun)
  );

  assign obj_packet = (hcount < 8'd240) ? pkt_mem[hcount] : 20'd0;
  always #5 clock = ~clock;

  typedef struct {int x; int pri; int idx; bit op; bit se; bit wi;} px_t;
  typedef struct {bit en; logic [19:0] k; bit op; bit se; bit wi;} dv_t;

  px_t q[$];
  int  popped[$];
  int  m_lc, m_line;
  bit  m_ovr;
  int  n_vec = 0, n_bad = 0;

  function automatic logic [19:0] mk(int pri, int mode, int w, int idx);
    logic [19:0] k;
    k = 20'd0;
    k[19:18] = 2'(pri);
    k[17:15] = 3'd5;
    k[14:13] = 2'(mode);
    k[8]     = 1'(w);
    k[7:0]   = 8'(idx);
    return k;
  endfunction

  function automatic px_t ref_pix(int p, bit en, logic [19:0] k);
    px_t r;
    bit vis;
    vis   = en && k[8] && (k[7:0] != 8'd0);
    r.x   = p;
    r.pri = int'(k[19:18]);
    r.idx = int'(k[7:0]);
    r.op  = vis && (k[14:13] != 2'd2);
    r.se  = vis && (k[14:13] == 2'd1);
    r.wi  = vis && (k[14:13] == 2'd2);
    return r;
  endfunction

  function automatic int got(int i);
    return (popped.size() > i) ? popped[i] : -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d expected %0d (model line %0d lc %0d)", name, act, exp, m_line, m_lc);
    end
  endtask

  // Reference timeline: cycle index within the line, line within the frame, a queue of pixels.
  task automatic model_edge();
    if (!reset) begin
      m_lc = 0; m_line = 0; m_ovr = 0; q.delete();
      return;
    end
    if (q.size() > 0 && pix_ready) q.delete(0);
    if (m_lc % 4 == 1 && m_lc < HB && m_line < VA) begin
      if (q.size() < 2) q.push_back(ref_pix(m_lc / 4, enable, pkt_mem[m_lc / 4]));
      else m_ovr = 1;
    end
    if (m_lc == CPL - 1) begin
      m_lc = 0;
      if (m_line == VT - 1) begin m_line = 0; m_ovr = 0; end
      else m_line++;
    end else m_lc++;
  endtask

  task automatic model_check();
    chk("hcount", hcount, (m_lc < HB) ? m_lc / 4 : 0);
    chk("vcount", vcount, m_line);
    chk("hblank", hblank, m_lc >= HB);
    chk("vblank", vblank, m_line >= VA);
    chk("pix_valid", pix_valid, q.size() > 0);
    chk("pix_overrun", pix_overrun, m_ovr);
    if (q.size() > 0) begin
      chk("pix_x", pix_x, q[0].x);
      chk("pix_pri", pix_pri, q[0].pri);
      chk("pix_index", pix_index, q[0].idx);
      chk("pix_opaque", pix_opaque, q[0].op);
      chk("pix_semitrans", pix_semitrans, q[0].se);
      chk("pix_win", pix_win, q[0].wi);
    end
  endtask

  task automatic step();
    if (reset && pix_valid === 1'b1 && pix_ready) popped.push_back(int'(pix_x));
    @(posedge clock);
    model_edge();
    @(negedge clock);
    model_check();
  endtask

  task automatic wait_until(int line, int lc, int max);
    int n;
    n = 0;
    while (!(m_line == line && m_lc == lc)) begin
      if (n >= max) begin
        n_vec++; n_bad++;
        $display("FAIL wait_until: timed out at line %0d lc %0d, wanted line %0d lc %0d", m_line, m_lc, line, lc);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_hcount"}, hcount, 0);
    chk({tag, "_vcount"}, vcount, 0);
    chk({tag, "_hblank"}, hblank, 0);
    chk({tag, "_vblank"}, vblank, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_x"}, pix_x, 0);
    chk({tag, "_pri"}, pix_pri, 0);
    chk({tag, "_index"}, pix_index, 0);
    chk({tag, "_flags"}, {pix_opaque, pix_semitrans, pix_win}, 0);
    chk({tag, "_overrun"}, pix_overrun, 0);
  endtask

  dv_t dv [9];

  initial begin
    int n;
    bit ok;
    dv[0] = '{1'b1, mk(2, 0, 1, 'h13), 1'b1, 1'b0, 1'b0};
    dv[1] = '{1'b1, mk(1, 0, 1, 0),     1'b0, 1'b0, 1'b0};
    dv[2] = '{1'b1, mk(3, 0, 0, 'h44), 1'b0, 1'b0, 1'b0};
    dv[3] = '{1'b1, mk(0, 2, 1, 5),     1'b0, 1'b0, 1'b1};
    dv[4] = '{1'b1, mk(1, 1, 1, 'h7e), 1'b1, 1'b1, 1'b0};
    dv[5] = '{1'b0, mk(2, 0, 1, 'h13), 1'b0, 1'b0, 1'b0};
    dv[6] = '{1'b0, mk(2, 2, 1, 5),     1'b0, 1'b0, 1'b0};
    dv[7] = '{1'b1, mk(3, 3, 1, 'hff), 1'b1, 1'b0, 1'b0};
    dv[8] = '{1'b1, mk(0, 1, 0, 9),     1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 240; i++) pkt_mem[i] = mk(2, 0, 1, 'h13);

    // Reset state and first-pixel latency, then a full frame with a constant packet.
    reset = 1'b0; step(); step();
    reset_checks("reset");
    reset = 1'b1; popped.delete();
    chk("first_valid_c0", pix_valid, 0);
    step(); chk("first_valid_c1", pix_valid, 0);
    step(); chk("first_valid_c2", pix_valid, 1);
    chk("first_pri", pix_pri, 2);
    chk("first_index", pix_index, 'h13);
    chk("first_opaque", pix_opaque, 1);
    for (int c = 3; c <= CPL; c++) step();
    chk("vcount_at_1232", vcount, 1);
    chk("line0_count", popped.size(), 240);
    ok = 1;
    for (int i = 0; i < popped.size(); i++) if (popped[i] != i) ok = 0;
    chk("line0_order", ok, 1);
    for (int c = CPL + 1; c <= CPL * VT; c++) step();
    chk("vcount_frame_wrap", vcount, 0);
    chk("frame_pixel_total", popped.size(), VA * 240);
    chk("frame_overrun", pix_overrun, 0);

    // Decode sweep: one packet per slot on line 0, enable switched just before each slot.
    for (int i = 0; i < 9; i++) begin
      wait_until(0, 4 * i, 64);
      enable = dv[i].en;
      pkt_mem[i] = dv[i].k;
      n = 0;
      while (!(pix_valid && pix_x == 8'(i)) && n < 8) begin step(); n++; end
      chk("sweep_found", pix_valid && pix_x == 8'(i), 1);
      chk("sweep_pri", pix_pri, int'(dv[i].k[19:18]));
      chk("sweep_index", pix_index, int'(dv[i].k[7:0]));
      chk("sweep_opaque", pix_opaque, dv[i].op);
      chk("sweep_semitrans", pix_semitrans, dv[i].se);
      chk("sweep_win", pix_win, dv[i].wi);
    end

    // Random packets, ready and enable until line 5.
    for (int i = 0; i < 240; i++) pkt_mem[i] = 20'($urandom);
    n = 0;
    while (!(m_line == 5 && m_lc == 490) && n < 10000) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) pkt_mem[$urandom_range(0, 239)] = 20'($urandom);
      step();
      n++;
    end
    chk("random_reached_line5", m_line * CPL + m_lc, 5 * CPL + 490);

    // Mid-frame reset with two pixels queued.
    pix_ready = 1'b0; enable = 1'b1;
    wait_until(5, 500, 32);
    chk("queued_before_reset", pix_valid, 1);
    for (int i = 0; i < 240; i++) pkt_mem[i] = mk(i % 4, 0, 1, i + 1);
    reset = 1'b0; step();
    reset_checks("midreset");
    reset = 1'b1;

    // Backpressure: ready low for cycles 2..9 after release.
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("bp_valid", pix_valid, k >= 2);
      if (k >= 2) begin
        chk("bp_hold_x", pix_x, 0);
        chk("bp_hold_index", pix_index, 1);
      end
    end
    step();
    chk("bp_overrun_set", pix_overrun, 1);
    popped.delete(); pix_ready = 1'b1;
    n = 0;
    while (popped.size() < 3 && n < 30) begin step(); n++; end
    chk("bp_order0", got(0), 0);
    chk("bp_order1", got(1), 1);
    chk("bp_order2", got(2), 3);
    wait_until(VT - 1, CPL - 1, 30000);
    chk("bp_overrun_sticky", pix_overrun, 1);
    step();
    chk("bp_overrun_cleared", pix_overrun, 0);
    chk("bp_frame_start_vcount", vcount, 0);

    // Full FIFO with ready rising in the same cycle as the next push.
    reset = 1'b0; pix_ready = 1'b0; step(); step();
    reset = 1'b1;
    for (int k = 1; k <= 9; k++) step();
    chk("edge_full_valid", pix_valid, 1);
    popped.delete(); pix_ready = 1'b1;
    n = 0;
    while (popped.size() < 3 && n < 30) begin step(); n++; end
    chk("edge_overrun", pix_overrun, 0);
    chk("edge_order0", got(0), 0);
    chk("edge_order1", got(1), 1);
    chk("edge_order2", got(2), 2);

    for (int c = 0; c < 2000; c++) begin
      pix_ready = ($urandom_range(0, 1) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
